serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_ctrl_fa_bit.sv | 21 ++
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single-bit full adder: two half-add stages and an OR for the carry.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  // First half-add on the operands, second on the partial sum and carry-in
  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one full-add per cycle through a shared bit cell,
// LSB first. Optional signed-overflow output enabled by macro SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             commit;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s;
  logic             fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             carry_msb;
`endif

  assign last = (cnt == CW'(WIDTH - 1));

  // The one shared bit cell, fed from the operand LSBs and the running carry
  fa_bit u_fa (
    .x   (opa[0]),
    .y   (opb[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a start coinciding with the done pulse is not accepted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the state
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE:    load   = start && !done;
      RUN:     step   = 1'b1;
      DONE:    commit = 1'b1;
      default: ;
    endcase
  end

  // Operand/result shift registers, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      carry_msb <= 1'b0;
`endif
    end else if (load) begin
      opa   <= a;
      opb   <= b;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      carry_msb <= 1'b0;
`endif
    end else if (step) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      res   <= {fa_s, res[WIDTH-1:1]};
      carry <= fa_co;
      cnt   <= last ? cnt : cnt + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
      // After the last step this holds the carry into the MSB
      carry_msb <= carry;
`endif
    end
  end

  // Registered outputs; sum/cout/ovf change only when leaving DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      done <= commit;
      if (commit) begin
        sum  <= res;
        cout <= carry;
`ifdef SERIAL_ADD_OVF_EN
        ovf  <= carry_msb ^ carry;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=16 instances).
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  sum;
  logic        cout;
  logic        ovf;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        cout16;
  logic        ovf16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf16)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf   = 1'b0;
  assign ovf16 = 1'b0;
`endif

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One addition on the 8-bit instance; returns at the negedge of the done cycle
  task automatic op8(input logic [7:0] xa, input logic [7:0] xb,
                     output logic [7:0] s, output logic c, output logic o,
                     output int lat, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~xa; b = ~xb;
    lat = 0;
    busy_ok = busy;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!done) busy_ok = busy_ok & busy;
    end
    s = sum; c = cout; o = ovf;
  endtask

  task automatic op16(input logic [15:0] xa, input logic [15:0] xb,
                      output logic [15:0] s, output logic c, output logic o, output int lat);
    @(negedge clk);
    start16 = 1'b1; a16 = xa; b16 = xb;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    s = sum16; c = cout16; o = ovf16;
  endtask

  initial begin
    logic [7:0]  s;
    logic        c;
    logic        o;
    logic        bok;
    logic [15:0] s16;
    logic [16:0] full;
    logic [8:0]  full8;
    logic [7:0]  ia;
    logic [7:0]  ib;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        eo;
    int          lat;
    int          ndone;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
    tbl[5] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tbl[7] = '{8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
    tbl[8] = '{8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
    tbl[9] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = 8'h0; b = 8'h0;
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'h0, busy, done, cout, ovf}, 32'h0);
    chk("reset_sum", 32'(sum), 32'h0);
    rst_n = 1'b1;

    // Directed table: result, carry, overflow, latency and busy window
    for (int i = 0; i < 10; i++) begin
      op8(tbl[i].va, tbl[i].vb, s, c, o, lat, bok);
      chk($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_cout", i), 32'(c), 32'(tbl[i].ec));
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 32'(o), 32'(tbl[i].eo));
`endif
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd9);
      chk($sformatf("tbl%0d_busy", i), 32'(bok), 32'd1);
    end

    // start held high through RUN and the done cycle: exactly one done
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF;
    ndone = 0; lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done) ndone++;
    start = 1'b0;
    chk("hold_start_sum", 32'(sum), 32'h46);
    chk("hold_start_latency", 32'(lat), 32'd9);
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("hold_start_done_count", 32'(ndone), 32'd1);
    chk("hold_start_idle", 32'(busy), 32'd0);
    op8(8'hFF, 8'hFF, s, c, o, lat, bok);
    chk("after_hold_sum", 32'(s), 32'hFE);
    chk("after_hold_cout", 32'(c), 32'd1);

    // Reset three cycles into RUN abandons the addition
    @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_sum", 32'(sum), 32'h0);
    chk("midrun_reset_cout", 32'(cout), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrun_reset_no_done", 32'(ndone), 32'd0);
    op8(8'hA5, 8'h5A, s, c, o, lat, bok);
    chk("post_reset_sum", 32'(s), 32'hFF);
    chk("post_reset_cout", 32'(c), 32'd0);

    // Strided sweep over the 8-bit operand space, boundaries included
    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < 18; j++) begin
        ia = (i == 17) ? 8'hFF : 8'(i * 15);
        ib = (j == 17) ? 8'hFF : 8'(j * 15 + 1);
        full8 = 9'(ia) + 9'(ib);
        op8(ia, ib, s, c, o, lat, bok);
        chk($sformatf("sweep_%02h_%02h", ia, ib), 32'({c, s}), 32'(full8));
      end
    end

    // Random pairs on the 16-bit instance
    for (int k = 0; k < 60; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) begin ra = 16'hFFFF; rb = 16'h0001; end
      if (k == 1) begin ra = 16'h7FFF; rb = 16'h0001; end
      full = 17'(ra) + 17'(rb);
      eo = (ra[15] == rb[15]) && (full[15] != ra[15]);
      op16(ra, rb, s16, c, o, lat);
      chk($sformatf("w16_%04h_%04h", ra, rb), 32'({c, s16}), 32'(full));
      chk($sformatf("w16_lat_%0d", k), 32'(lat), 32'd17);
`ifdef SERIAL_ADD_OVF_EN
      chk($sformatf("w16_ovf_%0d", k), 32'(o), 32'(eo));
`else
      if (eo) ra = rb;
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
